dsc_stream_tx: RTL and testbench
================================

DSC_STREAM_TX -- requirements
Module: dsc_stream_tx

Interface
REQ-001 Parameter WIDTH, default 5, operand width; stream length N = 2^WIDTH bits.
REQ-002 Parameter LANES, default 2, bits emitted per beat; power of two, 1..N; beats per stream C = N/LANES.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous reset, active-low.
REQ-006 en  input  1  beat enable; 0 stalls streaming.
REQ-007 repeat  input  1  1 = re-emit current operand when its stream ends.
REQ-008 bin_in  input  WIDTH  unsigned operand.
REQ-009 in_valid  input  1  operand offered.
REQ-010 in_ready  output  1  operand slot free.
REQ-011 sn_out  output  LANES  current beat, lane j = stream bit c*LANES+j.
REQ-012 sn_valid  output  1  sn_out carries a beat this cycle.
REQ-013 last  output  1  final beat (c = C-1) of a stream.
REQ-014 done  output  1  one-cycle pulse, stream finished and block idle.

Function
REQ-015 Encoding SHALL be unary/thermometer: stream bit k = 1 iff k < active operand; ones per stream = operand value, range 0..N-1.
REQ-016 Storage SHALL be one shadow register (+ full flag) and one active register; beat counter cnt of log2(C) bits, minimum 1 bit.
REQ-017 in_ready SHALL equal NOT shadow_full (registered, no combinational path from in_valid).
REQ-018 in_valid & in_ready at an edge SHALL capture bin_in into shadow and set shadow_full; accepted regardless of en or state.
REQ-019 States SHALL be IDLE and RUN only.
REQ-020 IDLE with shadow_full at an edge: active <= shadow, shadow_full <= 0, cnt <= 0, state <= RUN; independent of en.
REQ-021 sn_valid SHALL equal (state==RUN) & en; sn_out, last SHALL be 0 when sn_valid = 0; sn_out and last combinational from state, cnt, active, en.
REQ-022 last SHALL equal sn_valid & (cnt == C-1).
REQ-023 RUN, sn_valid=1, not last: cnt <= cnt+1.
REQ-024 Last beat priority: shadow_full -> load shadow as in REQ-020, stay RUN; else repeat=1 -> cnt <= 0, keep active, stay RUN; else -> IDLE, done <= 1.
REQ-025 Back-to-back streams SHALL have zero bubble beats between last and the next beat 0.
REQ-026 en=0 SHALL freeze cnt, state, active; shadow handshake continues.
REQ-027 done SHALL be registered, high exactly one cycle after the last beat that enters IDLE; never after a reloaded or repeated stream.
REQ-028 Latency: operand accepted at edge t (empty block) -> RUN from t+1, beat 0 visible in cycle after edge t+1 with en=1.
REQ-029 LANES = N SHALL give C = 1: every beat is a last beat.

Reset
REQ-030 rst=0 at an edge: state IDLE, cnt 0, active 0, shadow 0, shadow_full 0, done 0; hence in_ready 1, sn_valid 0, sn_out 0, last 0 next cycle.
REQ-031 Reset mid-stream SHALL abort it: no further beats, no last, no done; a pending shadow operand is discarded.

Verification (WIDTH=5, LANES=2, C=16, en=1 unless stated)
REQ-032 bin_in=5 single accept -> 16 beats: 11, 11, 01, then 13 x 00; last on beat 15; done one cycle later; in_ready back to 1 cycle after accept.
REQ-033 bin_in=0 -> 16 beats all 00, last and done still asserted; bin_in=31 -> 15 x 11 then 01 (31 ones).
REQ-034 Operands 7 then 9, in_valid held -> 32 contiguous sn_valid beats, ones counts 7 and 9, last at beats 15 and 31, single done after beat 31.
REQ-035 bin_in=12, en alternating 1/0 -> stream spans 32 cycles, identical beat sequence, sn_valid only on en=1 cycles.
REQ-036 repeat=1, bin_in=3 -> 3 ones per 16 beats continuously, no done; repeat dropped mid-stream -> done after that stream's last.
REQ-037 rst=0 at beat 8 of bin_in=20 -> next cycle sn_valid 0, in_ready 1, no last/done; new operand afterwards streams normally.

Source files
------------

// File: rtl/dsc_stream_tx.sv
// Unary (thermometer) stochastic stream transmitter: emits 2^WIDTH bits per operand,
// LANES bits per beat, with a one-deep shadow register so streams run back-to-back.
module dsc_stream_tx #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             repeat_en,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] sn_out,
  output logic             sn_valid,
  output logic             last,
  output logic             done
);

  localparam int unsigned N  = 1 << WIDTH;
  localparam int unsigned C  = N / LANES;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 0;
  localparam logic [CW-1:0] CntMax = CW'(C - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             done_q, done_d;

  logic             accept;
  logic             is_last;
  logic [WIDTH:0]   base;

  assign in_ready = !shadow_full_q;
  assign accept   = in_valid && !shadow_full_q;
  assign done     = done_q;

  // Beat outputs: lane j carries stream bit k = cnt*LANES + j, set iff k < active.
  always_comb begin
    sn_valid = (state_q == StRun) && en;
    is_last  = (cnt_q == CntMax);
    last     = sn_valid && is_last;
    base     = (WIDTH + 1)'(cnt_q) << LW;
    sn_out   = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      sn_out[j] = sn_valid && ((base + (WIDTH + 1)'(j)) < {1'b0, active_q});
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    done_d        = 1'b0;

    // Only an empty shadow can accept, and only a full one can be consumed, so the
    // two updates below never collide.
    if (accept) begin
      shadow_d      = bin_in;
      shadow_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (shadow_full_q) begin
          active_d      = shadow_q;
          shadow_full_d = 1'b0;
          cnt_d         = '0;
          state_d       = StRun;
        end
      end
      StRun: begin
        if (sn_valid) begin
          if (!is_last) begin
            cnt_d = cnt_q + CW'(1);
          end else if (shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
            cnt_d         = '0;
          end else if (repeat_en) begin
            cnt_d = '0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_dsc_stream_tx.sv
// Directed self-checking bench for dsc_stream_tx (WIDTH=5, LANES=2, 16 beats per stream).
module tb_dsc_stream_tx;

  logic       clk;
  logic       rst;
  logic       en;
  logic       repeat_en;
  logic [4:0] bin_in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sn_out;
  logic       sn_valid;
  logic       last;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stray    = 0;

  logic [1:0] beat_q[$];
  logic       last_q[$];
  int         bcyc_q[$];
  int         done_q[$];

  dsc_stream_tx #(
    .WIDTH(5),
    .LANES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .repeat_en(repeat_en),
    .bin_in   (bin_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sn_out   (sn_out),
    .sn_valid (sn_valid),
    .last     (last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat and done pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sn_valid) begin
      beat_q.push_back(sn_out);
      last_q.push_back(last);
      bcyc_q.push_back(cyc);
    end else if (last || sn_out != 2'b00) begin
      stray = stray + 1;
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    beat_q.delete();
    last_q.delete();
    bcyc_q.delete();
    done_q.delete();
  endtask

  task automatic send(input logic [4:0] val);
    bin_in   = val;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  function automatic logic [1:0] exp_beat(input int val, input int c);
    logic [1:0] r;
    for (int j = 0; j < 2; j++) r[j] = ((c * 2 + j) < val);
    return r;
  endfunction

  // Compare one 16-beat stream in the log starting at index base.
  task automatic check_beats(input string tag, input int val, input int base);
    int ones;
    ones = 0;
    for (int c = 0; c < 16; c++) begin
      check_eq($sformatf("%s_beat%0d", tag, c), 32'(beat_q[base + c]), 32'(exp_beat(val, c)));
      check_eq($sformatf("%s_last%0d", tag, c), 32'(last_q[base + c]), 32'(c == 15));
      ones += $countones(beat_q[base + c]);
    end
    check_eq({tag, "_ones"}, ones, val);
  endtask

  task automatic single(input string tag, input logic [4:0] val);
    clear_log();
    send(val);
    tick(22);
    check_eq({tag, "_nbeats"}, beat_q.size(), 16);
    check_beats(tag, int'(val), 0);
    check_eq({tag, "_ndone"}, done_q.size(), 1);
    check_eq({tag, "_done_cyc"}, done_q[0], bcyc_q[15] + 1);
  endtask

  initial begin
    int gaps;
    rst       = 1'b0;
    en        = 1'b1;
    repeat_en = 1'b0;
    bin_in    = '0;
    in_valid  = 1'b0;
    tick(2);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_sn_valid", sn_valid, 0);
    check_eq("rst_sn_out", sn_out, 0);
    check_eq("rst_last", last, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b1;
    tick(1);

    // bin_in = 5: 11, 11, 01, then zeros
    clear_log();
    send(5'd5);
    check_eq("b5_ready_after_accept", in_ready, 0);
    check_eq("b5_no_beat_yet", sn_valid, 0);
    tick(1);
    check_eq("b5_ready_back", in_ready, 1);
    check_eq("b5_beat0_now", sn_out, 2'b11);
    tick(21);
    check_eq("b5_nbeats", beat_q.size(), 16);
    check_eq("b5_b0", beat_q[0], 2'b11);
    check_eq("b5_b1", beat_q[1], 2'b11);
    check_eq("b5_b2", beat_q[2], 2'b01);
    check_eq("b5_b3", beat_q[3], 2'b00);
    check_beats("b5", 5, 0);
    check_eq("b5_contig", bcyc_q[15] - bcyc_q[0], 15);
    check_eq("b5_ndone", done_q.size(), 1);
    check_eq("b5_done_cyc", done_q[0], bcyc_q[15] + 1);
    check_eq("b5_idle_valid", sn_valid, 0);

    single("b0", 5'd0);
    single("b31", 5'd31);
    check_eq("b31_b14", beat_q[14], 2'b11);
    check_eq("b31_b15", beat_q[15], 2'b01);

    // 7 then 9 back-to-back, in_valid held until 9 is taken
    clear_log();
    bin_in   = 5'd7;
    in_valid = 1'b1;
    tick(1);
    bin_in = 5'd9;
    tick(2);
    in_valid = 1'b0;
    tick(40);
    check_eq("b2b_nbeats", beat_q.size(), 32);
    check_eq("b2b_contig", bcyc_q[31] - bcyc_q[0], 31);
    check_beats("b2b_a", 7, 0);
    check_beats("b2b_b", 9, 16);
    check_eq("b2b_ndone", done_q.size(), 1);
    check_eq("b2b_done_cyc", done_q[0], bcyc_q[31] + 1);

    // bin_in = 12 with en toggling every cycle
    clear_log();
    send(5'd12);
    tick(1);
    for (int i = 0; i < 40; i++) begin
      en = (i % 2 == 0);
      tick(1);
    end
    en = 1'b1;
    tick(2);
    check_eq("en_nbeats", beat_q.size(), 16);
    check_beats("en", 12, 0);
    check_eq("en_span", bcyc_q[15] - bcyc_q[0], 30);
    gaps = 0;
    for (int i = 1; i < 16; i++) if (bcyc_q[i] - bcyc_q[i-1] != 2) gaps++;
    check_eq("en_gaps", gaps, 0);
    check_eq("en_ndone", done_q.size(), 1);

    // repeat with bin_in = 3, then drop repeat mid-stream
    clear_log();
    repeat_en = 1'b1;
    send(5'd3);
    tick(1 + 48);
    check_eq("rep_nbeats48", beat_q.size(), 48);
    check_eq("rep_no_done", done_q.size(), 0);
    tick(5);
    repeat_en = 1'b0;
    tick(30);
    check_eq("rep_nbeats", beat_q.size(), 64);
    check_eq("rep_contig", bcyc_q[63] - bcyc_q[0], 63);
    check_beats("rep_a", 3, 0);
    check_beats("rep_b", 3, 16);
    check_beats("rep_d", 3, 48);
    check_eq("rep_ndone", done_q.size(), 1);
    check_eq("rep_done_cyc", done_q[0], bcyc_q[63] + 1);

    // reset at beat 8 of bin_in = 20 with a pending shadow operand
    clear_log();
    send(5'd20);
    tick(5);
    bin_in   = 5'd17;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check_eq("rst_mid_shadow_full", in_ready, 0);
    tick(3);
    rst = 1'b0;
    tick(1);
    check_eq("rst_mid_valid", sn_valid, 0);
    check_eq("rst_mid_ready", in_ready, 1);
    check_eq("rst_mid_last", last, 0);
    rst = 1'b1;
    tick(20);
    check_eq("rst_mid_nbeats", beat_q.size(), 9);
    check_eq("rst_mid_b8", beat_q[8], 2'b11);
    check_eq("rst_mid_ndone", done_q.size(), 0);
    gaps = 0;
    for (int i = 0; i < beat_q.size(); i++) if (last_q[i]) gaps++;
    check_eq("rst_mid_nlast", gaps, 0);

    single("after_rst", 5'd6);
    check_eq("stray_outputs", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
